// File: rtl/fifo_wr_serializer_if.sv
// rtl/fifo_wr_serializer_if.sv - word intake, FIFO write/pop and read-grant signals of the serializer
interface fifo_wr_serializer_if #(
    parameter int WORD_W = 16,
    parameter int NIB_W  = 4
);
    logic              s_valid;
    logic [WORD_W-1:0] s_data;
    logic              s_ready;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_en;
    logic [NIB_W-1:0]  fifo_din;
    logic              rd_req;
    logic              rd_grant;
    logic              rd_vld;
    logic              busy;

    // master is the serializer side, slave is the upstream/FIFO/consumer side
    modport master (
        input  s_valid, s_data, fifo_full, fifo_empty, rd_req,
        output s_ready, fifo_en, fifo_din, rd_grant, rd_vld, busy
    );

    modport slave (
        output s_valid, s_data, fifo_full, fifo_empty, rd_req,
        input  s_ready, fifo_en, fifo_din, rd_grant, rd_vld, busy
    );
endinterface

// File: rtl/fifo_wr_serializer.sv
// rtl/fifo_wr_serializer.sv - splits words into LSB-first nibbles on the FIFO en line, alternating with pops under contention
module fifo_wr_serializer #(
    parameter int WORD_W = 16,
    parameter int NIB_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_wr_serializer_if.master  bus
);
    localparam int NIBS  = WORD_W / NIB_W;
    localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_shreg;
    logic [CNT_W-1:0]    r_nib_cnt;
    logic                r_last_wr;
    logic                r_rd_vld;

    logic                w_send;
    logic                w_wr_slot;
    logic                w_accept;
    logic                w_rd_grant;

    assign w_send = (r_state == SEND);

    // A write directly after a write yields the slot to a pending pop, so pops get at least every other cycle.
    assign w_wr_slot = w_send && !bus.fifo_full
                       && !(bus.rd_req && !bus.fifo_empty && r_last_wr);

    // rst gates the combinational outputs so they read inactive while reset is held.
    assign bus.s_ready  = rst && !w_send;
    assign w_accept     = bus.s_valid && bus.s_ready;
    assign w_rd_grant   = rst && !w_wr_slot && !bus.fifo_empty;

    assign bus.fifo_en  = w_wr_slot;
    assign bus.fifo_din = r_shreg[NIB_W-1:0];
    assign bus.rd_grant = w_rd_grant;
    assign bus.rd_vld   = r_rd_vld;
    assign bus.busy     = w_send;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_nib_cnt <= '0;
            r_last_wr <= 1'b0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_vld  <= w_rd_grant;
            r_last_wr <= w_wr_slot;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state   <= SEND;
                        r_shreg   <= bus.s_data;
                        r_nib_cnt <= '0;
                    end
                end
                SEND: begin
                    // On a stall or yielded slot the shift register and count simply hold.
                    if (w_wr_slot) begin
                        r_shreg   <= r_shreg >> NIB_W;
                        r_nib_cnt <= r_nib_cnt + 1'b1;
                        if (r_nib_cnt == LAST_NIB) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_serializer.sv
// tb/tb_fifo_wr_serializer.sv - randomized and directed self-checking bench for fifo_wr_serializer
module tb_fifo_wr_serializer;
    logic clk;
    logic rst;

    fifo_wr_serializer_if #(.WORD_W(16), .NIB_W(4)) bus ();

    fifo_wr_serializer #(.WORD_W(16), .NIB_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks;
    int unsigned errors;

    // Reference model: nibbles still owed for the current word, plus what happened last cycle.
    logic [3:0] m_q[$];
    bit         m_prev_wr;
    bit         m_prev_grant;

    logic       e_ready, e_en, e_grant, e_vld, e_busy;
    logic [3:0] e_din;
    logic [8:0] e_vec;

    function automatic logic [8:0] obs();
        return {bus.s_ready, bus.fifo_en, bus.fifo_din, bus.rd_grant, bus.rd_vld, bus.busy};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_prev_wr    = 1'b0;
        m_prev_grant = 1'b0;
    endtask

    task automatic model_eval();
        if (!rst) begin
            {e_ready, e_en, e_din, e_grant, e_vld, e_busy} = '0;
        end else begin
            e_busy  = (m_q.size() != 0);
            e_ready = !e_busy;
            e_en    = e_busy && !bus.fifo_full && !(bus.rd_req && !bus.fifo_empty && m_prev_wr);
            e_din   = e_busy ? m_q[0] : 4'h0;
            e_grant = !e_en && !bus.fifo_empty;
            e_vld   = m_prev_grant;
        end
        e_vec = {e_ready, e_en, e_din, e_grant, e_vld, e_busy};
    endtask

    task automatic model_edge();
        logic [15:0] w;
        if (!rst) begin
            model_reset();
        end else begin
            m_prev_grant = e_grant;
            m_prev_wr    = e_en;
            if (e_en) void'(m_q.pop_front());
            if (!e_busy && bus.s_valid) begin
                w = bus.s_data;
                for (int i = 0; i < 4; i++) m_q.push_back(w[i*4 +: 4]);
            end
        end
    endtask

    task automatic set_inputs(logic v, logic [15:0] d, logic full, logic empty, logic req);
        bus.s_valid    = v;
        bus.s_data     = d;
        bus.fifo_full  = full;
        bus.fifo_empty = empty;
        bus.rd_req     = req;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_inputs(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if (obs() !== e_vec) begin
                errors++;
                $display("FAIL reset_hold_c%0d: got %b want %b", c, obs(), e_vec);
            end
            model_edge();
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        model_eval();
        checks++;
        if (obs() !== 9'b1_0_0000_0_0_0) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", obs(), 9'b1_0_0000_0_0_0);
        end
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [3:0] got[$];
        logic [3:0] exp_n[4];
        logic [4:0] en_hist;
        logic       rdy5;
        exp_n = '{4'h3, 4'hC, 4'h5, 4'hA};
        en_hist = '0;
        rdy5 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            set_inputs(c == 0, 16'hA5C3, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            model_eval();
            checks++;
            if (obs() !== e_vec) begin
                errors++;
                $display("FAIL basic_c%0d: got %b want %b", c, obs(), e_vec);
            end
            if (c >= 1 && c <= 5) en_hist[c-1] = bus.fifo_en;
            if (c == 5) rdy5 = bus.s_ready;
            if (bus.fifo_en) got.push_back(bus.fifo_din);
            model_edge();
            @(posedge clk); #1;
        end
        checks++;
        if (en_hist !== 5'b01111) begin
            errors++;
            $display("FAIL basic_en_pattern: got %b want %b", en_hist, 5'b01111);
        end
        checks++;
        if (rdy5 !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready_6th: got %b want 1", rdy5);
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL basic_count: got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_n[i]) begin
                    errors++;
                    $display("FAIL basic_nib%0d: got %h want %h", i, got[i], exp_n[i]);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        logic [3:0] got[$];
        logic [3:0] exp_n[4];
        exp_n = '{4'h3, 4'hC, 4'h5, 4'hA};
        for (int c = 0; c < 9; c++) begin
            set_inputs(c == 0, 16'hA5C3, (c >= 3 && c <= 5), 1'b0, 1'b0);
            @(negedge clk);
            model_eval();
            checks++;
            if (obs() !== e_vec) begin
                errors++;
                $display("FAIL stall_c%0d: got %b want %b", c, obs(), e_vec);
            end
            if (c >= 3 && c <= 5) begin
                checks++;
                if ({bus.fifo_en, bus.fifo_din} !== 5'b0_0101) begin
                    errors++;
                    $display("FAIL stall_hold_c%0d: got en=%b din=%h want en=0 din=5", c, bus.fifo_en, bus.fifo_din);
                end
            end
            if (bus.fifo_en) got.push_back(bus.fifo_din);
            model_edge();
            @(posedge clk); #1;
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_n[i]) begin
                    errors++;
                    $display("FAIL stall_nib%0d: got %h want %h", i, got[i], exp_n[i]);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [3:0] got[$];
        logic [6:0] en_hist, gr_hist, vld_hist;
        en_hist = '0; gr_hist = '0; vld_hist = '0;
        for (int c = 0; c < 9; c++) begin
            set_inputs(c == 0, 16'h1234, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            model_eval();
            checks++;
            if (obs() !== e_vec) begin
                errors++;
                $display("FAIL contend_c%0d: got %b want %b", c, obs(), e_vec);
            end
            if (c >= 1 && c <= 7) begin
                en_hist[7-c] = bus.fifo_en;
                gr_hist[7-c] = bus.rd_grant;
            end
            if (c >= 2 && c <= 8) vld_hist[8-c] = bus.rd_vld;
            if (bus.fifo_en) got.push_back(bus.fifo_din);
            model_edge();
            @(posedge clk); #1;
        end
        checks++;
        if (en_hist !== 7'b1010101) begin
            errors++;
            $display("FAIL contend_en_pattern: got %b want %b", en_hist, 7'b1010101);
        end
        checks++;
        if (gr_hist !== 7'b0101010) begin
            errors++;
            $display("FAIL contend_grant: got %b want %b", gr_hist, 7'b0101010);
        end
        checks++;
        if (vld_hist !== gr_hist) begin
            errors++;
            $display("FAIL contend_vld_delay: got %b want %b", vld_hist, gr_hist);
        end
        checks++;
        if (got.size() != 4 || got[0] !== 4'h4 || got[1] !== 4'h3 || got[2] !== 4'h2 || got[3] !== 4'h1) begin
            errors++;
            $display("FAIL contend_nibs: got %0d nibbles want 4,3,2,1", got.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got[$];
        for (int c = 0; c < 3; c++) begin
            set_inputs(c == 0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            model_eval();
            checks++;
            if (obs() !== e_vec) begin
                errors++;
                $display("FAIL rstmid_pre_c%0d: got %b want %b", c, obs(), e_vec);
            end
            model_edge();
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs() !== 9'b0) begin
            errors++;
            $display("FAIL rstmid_async: got %b want %b", obs(), 9'b0);
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            set_inputs(c == 0, 16'h0001, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            model_eval();
            checks++;
            if (obs() !== e_vec) begin
                errors++;
                $display("FAIL rstmid_post_c%0d: got %b want %b", c, obs(), e_vec);
            end
            if (bus.fifo_en) got.push_back(bus.fifo_din);
            model_edge();
            @(posedge clk); #1;
        end
        checks++;
        if (got.size() != 4 || got[0] !== 4'h1 || got[1] !== 4'h0 || got[2] !== 4'h0 || got[3] !== 4'h0) begin
            errors++;
            $display("FAIL rstmid_nibs: got %0d nibbles want 1,0,0,0", got.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got[$];
        int acc;
        int acc_cyc[2];
        acc = 0;
        acc_cyc = '{-1, -1};
        for (int c = 0; c < 13; c++) begin
            set_inputs(acc < 2, (acc >= 1) ? 16'h2222 : 16'h1111, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            model_eval();
            checks++;
            if (obs() !== e_vec) begin
                errors++;
                $display("FAIL b2b_c%0d: got %b want %b", c, obs(), e_vec);
            end
            if (bus.fifo_en) got.push_back(bus.fifo_din);
            if (bus.s_ready && bus.s_valid && acc < 2) begin
                acc_cyc[acc] = c;
                acc++;
            end
            model_edge();
            @(posedge clk); #1;
        end
        checks++;
        if (acc != 2 || (acc_cyc[1] - acc_cyc[0]) != 5) begin
            errors++;
            $display("FAIL b2b_gap: got accepts=%0d gap=%0d want accepts=2 gap=5", acc, acc_cyc[1] - acc_cyc[0]);
        end
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got[i] !== ((i < 4) ? 4'h1 : 4'h2)) begin
                    errors++;
                    $display("FAIL b2b_nib%0d: got %h want %h", i, got[i], (i < 4) ? 4'h1 : 4'h2);
                end
            end
        end
    endtask

    task automatic test_random();
        logic full, empty;
        for (int c = 0; c < 600; c++) begin
            full  = ($urandom_range(0, 3) == 0);
            empty = full ? 1'b0 : ($urandom_range(0, 2) == 0);
            set_inputs($urandom_range(0, 1), 16'($urandom), full, empty, $urandom_range(0, 1));
            @(negedge clk);
            model_eval();
            checks++;
            if (obs() !== e_vec) begin
                errors++;
                $display("FAIL random_c%0d: got %b want %b", c, obs(), e_vec);
            end
            model_edge();
            @(posedge clk); #1;
        end
        set_inputs(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        set_inputs(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_full_stall();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
